// File: rtl/run_supervisor.sv
// Run controller for N_CPU cores: start-up delay, run enable, per-channel finish/status tracking and watchdog.
// Optional feature: define RUN_SUPERVISOR_AUTOSTART_EN to issue an implicit start once after reset release.
module run_supervisor #(
    parameter int N_CPU      = 1,
    parameter int INIT_DELAY = 3,
    parameter int TIMEOUT    = 1000,
    parameter int CW         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [N_CPU-1:0] o_run,
    input  logic [N_CPU-1:0] i_running,
    input  logic [N_CPU-1:0] i_status,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [N_CPU-1:0] o_fail_mask,
    output logic [CW-1:0]    o_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] DELAY_LD    = CW'(INIT_DELAY);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_t             state_q, state_d;
    logic [CW-1:0]      delay_q, delay_d;
    logic [CW-1:0]      cycles_q, cycles_d;
    logic [N_CPU-1:0]   started_q, started_d;
    logic [N_CPU-1:0]   finished_q, finished_d;
    logic [N_CPU-1:0]   status_q, status_d;
    logic [N_CPU-1:0]   run_q, run_d;
    logic [N_CPU-1:0]   fail_mask_q, fail_mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               enter_run_s;
    logic               enter_done_s;
    logic               timed_out_s;
    logic               auto_start_s;
    logic [N_CPU-1:0]   fin_new_s;

`ifdef RUN_SUPERVISOR_AUTOSTART_EN
    logic [1:0] boot_q, boot_d;

    // Boot sequencer: counts 0 -> 1 -> 2 after reset; the implicit start fires while it reads 1.
    always_comb begin
        boot_d = boot_q;
        if (boot_q != 2'd2) begin
            boot_d = boot_q + 2'd1;
        end else begin
            boot_d = boot_q;
        end
    end

    // Boot sequencer register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            boot_q <= 2'd0;
        end else begin
            boot_q <= boot_d;
        end
    end

    assign auto_start_s = (boot_q == 2'd1);
`else
    assign auto_start_s = 1'b0;
`endif

    // Next-state, per-channel tracking and result computation.
    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        cycles_d     = cycles_q;
        started_d    = started_q;
        finished_d   = finished_q;
        status_d     = status_q;
        fail_mask_d  = fail_mask_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        enter_run_s  = 1'b0;
        enter_done_s = 1'b0;
        timed_out_s  = 1'b0;
        fin_new_s    = {N_CPU{1'b0}};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start || (auto_start_s && (state_q == ST_IDLE))) begin
                    if (INIT_DELAY == 0) begin
                        enter_run_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        delay_d = DELAY_LD;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (delay_q <= CNT_ONE) begin
                    enter_run_s = 1'b1;
                end else begin
                    delay_d = delay_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                // A channel finishes on its first low running sample after having been seen high.
                fin_new_s  = started_q & ~i_running & ~finished_q;
                started_d  = started_q | i_running;
                finished_d = finished_q | fin_new_s;
                status_d   = (status_q & ~fin_new_s) | (i_status & fin_new_s);
                if (cycles_q >= TIMEOUT_LIM) begin
                    cycles_d = cycles_q;
                end else begin
                    cycles_d = cycles_q + CNT_ONE;
                end
                if (&finished_d) begin
                    enter_done_s = 1'b1;
                end else if (cycles_d >= TIMEOUT_LIM) begin
                    enter_done_s = 1'b1;
                    timed_out_s  = 1'b1;
                end else begin
                    enter_done_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_run_s) begin
            state_d     = ST_RUN;
            delay_d     = {CW{1'b0}};
            cycles_d    = {CW{1'b0}};
            started_d   = {N_CPU{1'b0}};
            finished_d  = {N_CPU{1'b0}};
            status_d    = {N_CPU{1'b0}};
            fail_mask_d = {N_CPU{1'b0}};
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
        end else if (enter_done_s) begin
            state_d     = ST_DONE;
            fail_mask_d = ~finished_d | ~status_d;
            timeout_d   = timed_out_s;
            pass_d      = ~(|(~finished_d | ~status_d)) & ~timed_out_s;
        end else begin
            state_d = state_d;
        end

        run_d  = (state_d == ST_RUN) ? {N_CPU{1'b1}} : {N_CPU{1'b0}};
        busy_d = (state_d == ST_WAIT) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            delay_q     <= {CW{1'b0}};
            cycles_q    <= {CW{1'b0}};
            started_q   <= {N_CPU{1'b0}};
            finished_q  <= {N_CPU{1'b0}};
            status_q    <= {N_CPU{1'b0}};
            run_q       <= {N_CPU{1'b0}};
            fail_mask_q <= {N_CPU{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            cycles_q    <= cycles_d;
            started_q   <= started_d;
            finished_q  <= finished_d;
            status_q    <= status_d;
            run_q       <= run_d;
            fail_mask_q <= fail_mask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_run       = run_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_timeout   = timeout_q;
    assign o_fail_mask = fail_mask_q;
    assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Directed bench for run_supervisor: a per-cycle vector table for a 4-channel run, then
// hand-written sequences for timeout, finish-on-timeout tie, reset mid-run and start-up behaviour.
module tb_run_supervisor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [3:0] running;
    logic [3:0] status;
    logic [3:0] run;
    logic       busy, done, pass, tmo;
    logic [3:0] mask;
    logic [7:0] cycles;

    logic       start0;
    logic [0:0] running0, status0, run0, mask0;
    logic       busy0, done0, pass0, tmo0;
    logic [7:0] cycles0;

    int n_checks = 0;
    int n_fail   = 0;

    run_supervisor #(.N_CPU(4), .INIT_DELAY(3), .TIMEOUT(20), .CW(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_run(run),
        .i_running(running), .i_status(status), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_timeout(tmo), .o_fail_mask(mask), .o_cycles(cycles)
    );

    run_supervisor #(.N_CPU(1), .INIT_DELAY(0), .TIMEOUT(20), .CW(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .o_run(run0),
        .i_running(running0), .i_status(status0), .o_busy(busy0), .o_done(done0),
        .o_pass(pass0), .o_timeout(tmo0), .o_fail_mask(mask0), .o_cycles(cycles0)
    );

    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic [3:0] running;
        logic [3:0] status;
        logic       run;
        logic       busy;
        logic       done;
        logic       pass;
        logic       tmo;
        logic [3:0] mask;
        logic [7:0] cycles;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] rn,
                                input logic [3:0] st, input logic e_run, input logic e_busy,
                                input logic e_done, input logic e_pass, input logic e_tmo,
                                input logic [3:0] e_mask, input logic [7:0] e_cyc);
        vec_t v;
        v.rst_n = r;  v.start = s;  v.running = rn;  v.status = st;
        v.run = e_run; v.busy = e_busy; v.done = e_done; v.pass = e_pass;
        v.tmo = e_tmo; v.mask = e_mask; v.cycles = e_cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_run, input logic e_busy,
                             input logic e_done, input logic e_pass, input logic e_tmo,
                             input logic [3:0] e_mask, input logic [7:0] e_cyc);
        check({tag, ".run"},    32'(run),    e_run ? 32'hF : 32'h0);
        check({tag, ".busy"},   32'(busy),   32'(e_busy));
        check({tag, ".done"},   32'(done),   32'(e_done));
        check({tag, ".pass"},   32'(pass),   32'(e_pass));
        check({tag, ".tmo"},    32'(tmo),    32'(e_tmo));
        check({tag, ".mask"},   32'(mask),   32'(e_mask));
        check({tag, ".cycles"}, 32'(cycles), 32'(e_cyc));
    endtask

    task automatic start_main();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("restart.run_entry", 32'(run), 32'hF);
        check("restart.cycles0", 32'(cycles), 32'h0);
    endtask

    initial begin
        // rst, start, running, status -> run, busy, done, pass, tmo, mask, cycles
        vecs[0]  = mk(1'b0, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[1]  = mk(1'b1, 1'b1, 4'h0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[2]  = mk(1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[3]  = mk(1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[4]  = mk(1'b1, 1'b0, 4'h0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[5]  = mk(1'b1, 1'b0, 4'hF, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd1);
        vecs[6]  = mk(1'b1, 1'b0, 4'hF, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd2);
        vecs[7]  = mk(1'b1, 1'b0, 4'hE, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd3);
        vecs[8]  = mk(1'b1, 1'b0, 4'hA, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4);
        vecs[9]  = mk(1'b1, 1'b0, 4'hA, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd5);
        vecs[10] = mk(1'b1, 1'b0, 4'h2, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd6);
        vecs[11] = mk(1'b1, 1'b0, 4'h2, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd7);
        vecs[12] = mk(1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'd8);
        vecs[13] = mk(1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'd8);
        vecs[14] = mk(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 8'd8);
        vecs[15] = mk(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 8'd8);
        vecs[16] = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 8'd8);
        vecs[17] = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
        vecs[18] = mk(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd1);
        vecs[19] = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd2);
        vecs[20] = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd2);

        rst_n = 1'b0; start = 1'b0; running = 4'h0; status = 4'h0;
        start0 = 1'b0; running0 = 1'b0; status0 = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rst_n   = vecs[i].rst_n;
            start   = vecs[i].start;
            running = vecs[i].running;
            status  = vecs[i].status;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].run, vecs[i].busy, vecs[i].done,
                      vecs[i].pass, vecs[i].tmo, vecs[i].mask, vecs[i].cycles);
        end

        // Watchdog: channel 0 never drops running, channels 1-3 finish with status 1.
        status = 4'hF;
        running = 4'h0;
        start_main();
        for (int k = 1; k <= 20; k++) begin
            running = (k == 1) ? 4'hF : 4'h1;
            step();
            if (k < 20) begin
                check($sformatf("tmo.busy%0d", k), 32'(busy), 32'h1);
                check($sformatf("tmo.cycles%0d", k), 32'(cycles), 32'(k));
            end else begin
                check_all("tmo.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 8'd20);
            end
        end

        // Last finish lands on the exact timeout cycle: finish wins.
        running = 4'h0;
        start_main();
        for (int k = 1; k <= 20; k++) begin
            running = (k < 20) ? 4'hF : 4'h0;
            step();
            if (k == 19) begin
                check("tie.busy19", 32'(busy), 32'h1);
            end else if (k == 20) begin
                check_all("tie.end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd20);
            end
        end

        // Zero-delay instance: start, reset mid-run, restart.
        running = 4'h0;
        start0 = 1'b1;
        step();
        check("d0.run_now", 32'(run0), 32'h1);
        check("d0.busy", 32'(busy0), 32'h1);
        start0 = 1'b0; running0 = 1'b1;
        step();
        step();
        check("d0.cycles2", 32'(cycles0), 32'h2);
        rst_n = 1'b0;
        step();
        check("rst.d0_outs", {run0, busy0, done0, pass0, tmo0, mask0, cycles0}, 32'h0);
        check("rst.main_outs", {run, busy, done, pass, tmo, mask, cycles}, 32'h0);
        rst_n = 1'b1; start0 = 1'b1; running0 = 1'b0;
        step();
        check("d0.rerun", 32'(run0), 32'h1);
        check("d0.recycles", 32'(cycles0), 32'h0);
        check("boot.busy1", 32'(busy), 32'h0);
        start0 = 1'b0; running0 = 1'b1;
        step();
`ifdef RUN_SUPERVISOR_AUTOSTART_EN
        check("boot.busy2", 32'(busy), 32'h1);
`else
        check("boot.busy2", 32'(busy), 32'h0);
`endif
        running0 = 1'b0; status0 = 1'b1;
        step();
        check("d0.done", 32'(done0), 32'h1);
        check("d0.pass", 32'(pass0), 32'h1);
        check("d0.run_off", 32'(run0), 32'h0);
        check("d0.cycles_end", 32'(cycles0), 32'h2);
`ifdef RUN_SUPERVISOR_AUTOSTART_EN
        check("boot.busy3", 32'(busy), 32'h1);
`else
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("idle.busy%0d", k), 32'(busy), 32'h0);
            check($sformatf("idle.run%0d", k), 32'(run), 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
